// File: rtl/regbank_ctrl.sv
// Write-port controller for a NUM_REGS x WIDTH register bank: arbitrates two requesters
// and runs a clear sweep after reset/clr_all. Define REGBANK_FIXED_PRIO_EN for fixed priority.
module regbank_ctrl #(
  parameter int NUM_REGS = 4,
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 2
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                clr_all_i,
  input  logic                req0_i,
  input  logic                req1_i,
  input  logic [1:0]          op0_i,
  input  logic [1:0]          op1_i,
  input  logic [ADDR_W-1:0]   addr0_i,
  input  logic [ADDR_W-1:0]   addr1_i,
  input  logic [WIDTH-1:0]    data0_i,
  input  logic [WIDTH-1:0]    data1_i,
  output logic                gnt0_o,
  output logic                gnt1_o,
  output logic                busy_o,
  output logic [WIDTH-1:0]    bank_d_o,
  output logic [NUM_REGS-1:0] bank_we_o,
  output logic [NUM_REGS-1:0] bank_set_o,
  output logic [NUM_REGS-1:0] bank_reset_o
);

  localparam int IDX_W = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_REGS - 1);
  localparam logic [NUM_REGS-1:0] ONE      = NUM_REGS'(1);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_PRESET = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  typedef enum logic [1:0] {
    ST_START,
    ST_SWEEP,
    ST_IDLE,
    ST_GRANT
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 rr_q;
  logic                 gnt0_q, gnt1_q, busy_q;
  logic [WIDTH-1:0]     bank_d_q;
  logic [NUM_REGS-1:0]  bank_we_q, bank_set_q, bank_reset_q;

  logic                 elig0_d, elig1_d, win_valid_d, win1_d, in_range_d;
  logic [1:0]           win_op_d;
  logic [ADDR_W-1:0]    win_addr_d;
  logic [WIDTH-1:0]     win_data_d;
  logic [NUM_REGS-1:0]  win_sel_d;

  // A requester whose grant is high this cycle has just been served; its held
  // request belongs to the transaction already issued.
  always_comb begin
    elig0_d = req0_i && (op0_i != OP_NOP) && !gnt0_q;
    elig1_d = req1_i && (op1_i != OP_NOP) && !gnt1_q;
`ifdef REGBANK_FIXED_PRIO_EN
    win_valid_d = elig0_d || (elig1_d && !(req0_i && (op0_i != OP_NOP)));
    win1_d      = !elig0_d;
`else
    win_valid_d = elig0_d || elig1_d;
    win1_d      = elig1_d && (!elig0_d || rr_q);
`endif
    win_op_d   = win1_d ? op1_i   : op0_i;
    win_addr_d = win1_d ? addr1_i : addr0_i;
    win_data_d = win1_d ? data1_i : data0_i;
    in_range_d = (int'(win_addr_d) < NUM_REGS);
    win_sel_d  = in_range_d ? (ONE << win_addr_d) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q      <= ST_START;
      idx_q        <= '0;
      rr_q         <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      busy_q       <= 1'b1;
      bank_d_q     <= '0;
      bank_we_q    <= '0;
      bank_set_q   <= '0;
      bank_reset_q <= '0;
    end else begin
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      bank_we_q    <= '0;
      bank_set_q   <= '0;
      bank_reset_q <= '0;
      case (state_q)
        ST_START: begin
          state_q      <= ST_SWEEP;
          idx_q        <= '0;
          busy_q       <= 1'b1;
          bank_reset_q <= ONE;
        end
        ST_SWEEP: begin
          if (idx_q == IDX_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            idx_q        <= idx_q + 1'b1;
            busy_q       <= 1'b1;
            bank_reset_q <= ONE << (idx_q + 1'b1);
          end
        end
        ST_IDLE, ST_GRANT: begin
          if (clr_all_i) begin
            state_q      <= ST_SWEEP;
            idx_q        <= '0;
            busy_q       <= 1'b1;
            bank_reset_q <= ONE;
          end else if (win_valid_d) begin
            state_q <= ST_GRANT;
            busy_q  <= 1'b0;
            rr_q    <= !win1_d;
            gnt0_q  <= !win1_d;
            gnt1_q  <= win1_d;
            case (win_op_d)
              OP_WRITE: begin
                bank_we_q <= win_sel_d;
                if (in_range_d) bank_d_q <= win_data_d;
              end
              OP_PRESET: bank_set_q   <= win_sel_d;
              OP_CLEAR:  bank_reset_q <= win_sel_d;
              default:   ;
            endcase
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_START;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign gnt0_o       = gnt0_q;
  assign gnt1_o       = gnt1_q;
  assign busy_o       = busy_q;
  assign bank_d_o     = bank_d_q;
  assign bank_we_o    = bank_we_q;
  assign bank_set_o   = bank_set_q;
  assign bank_reset_o = bank_reset_q;

endmodule

// File: tb/tb_regbank_ctrl.sv
// Directed bench for regbank_ctrl: a 4-register instance for the main behaviour and a
// 3-register instance for the out-of-range address case.
module tb_regbank_ctrl;

  logic       clk = 1'b0;
  logic       reset_n, clr_all;
  logic       req0, req1;
  logic [1:0] op0, op1, addr0, addr1;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, busy;
  logic [7:0] bank_d;
  logic [3:0] bank_we, bank_set, bank_rst;

  logic       r3_req0;
  logic [1:0] r3_op0, r3_addr0;
  logic [7:0] r3_data0;
  logic       g3_0, g3_1, busy3;
  logic [7:0] d3;
  logic [2:0] we3, set3, rst3;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  regbank_ctrl #(.NUM_REGS(4), .WIDTH(8), .ADDR_W(2)) u_dut (
    .clk_i(clk), .reset_ni(reset_n), .clr_all_i(clr_all),
    .req0_i(req0), .req1_i(req1), .op0_i(op0), .op1_i(op1),
    .addr0_i(addr0), .addr1_i(addr1), .data0_i(data0), .data1_i(data1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .busy_o(busy), .bank_d_o(bank_d),
    .bank_we_o(bank_we), .bank_set_o(bank_set), .bank_reset_o(bank_rst)
  );

  regbank_ctrl #(.NUM_REGS(3), .WIDTH(8), .ADDR_W(2)) u_dut3 (
    .clk_i(clk), .reset_ni(reset_n), .clr_all_i(1'b0),
    .req0_i(r3_req0), .req1_i(1'b0), .op0_i(r3_op0), .op1_i(2'b00),
    .addr0_i(r3_addr0), .addr1_i(2'b00), .data0_i(r3_data0), .data1_i(8'h00),
    .gnt0_o(g3_0), .gnt1_o(g3_1), .busy_o(busy3), .bank_d_o(d3),
    .bank_we_o(we3), .bank_set_o(set3), .bank_reset_o(rst3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_ctl(input string tag, input logic g0, input logic g1, input logic bz,
                         input logic [3:0] we, input logic [3:0] st, input logic [3:0] rs);
    chk({tag, ".gnt0"}, 32'(gnt0), 32'(g0));
    chk({tag, ".gnt1"}, 32'(gnt1), 32'(g1));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
    chk({tag, ".we"},   32'(bank_we),  32'(we));
    chk({tag, ".set"},  32'(bank_set), 32'(st));
    chk({tag, ".rst"},  32'(bank_rst), 32'(rs));
  endtask

  initial begin
    reset_n = 1'b0; clr_all = 1'b0;
    req0 = 1'b0; req1 = 1'b0; op0 = 2'b00; op1 = 2'b00;
    addr0 = 2'd0; addr1 = 2'd0; data0 = 8'h00; data1 = 8'h00;
    r3_req0 = 1'b0; r3_op0 = 2'b00; r3_addr0 = 2'd0; r3_data0 = 8'h00;

    step(); step();
    chk_ctl("reset", 0, 0, 1, 4'b0000, 4'b0000, 4'b0000);
    chk("reset.d", 32'(bank_d), 32'h00);

    // Sweep after release; clr_all held during the sweep must not restart it.
    reset_n = 1'b1;
    step(); chk_ctl("sweep0", 0, 0, 1, 4'b0000, 4'b0000, 4'b0001);
    clr_all = 1'b1;
    step(); chk_ctl("sweep1", 0, 0, 1, 4'b0000, 4'b0000, 4'b0010);
    step(); chk_ctl("sweep2", 0, 0, 1, 4'b0000, 4'b0000, 4'b0100);
    step(); chk_ctl("sweep3", 0, 0, 1, 4'b0000, 4'b0000, 4'b1000);
    clr_all = 1'b0;
    step(); chk_ctl("sweep_done", 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);

    // Single write from requester 0.
    req0 = 1'b1; op0 = 2'b01; addr0 = 2'd2; data0 = 8'hA5;
    step(); chk_ctl("wr_a5", 1, 0, 0, 4'b0100, 4'b0000, 4'b0000);
    chk("wr_a5.d", 32'(bank_d), 32'hA5);
    req0 = 1'b0; op0 = 2'b00;
    step(); chk_ctl("wr_a5_after", 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    chk("wr_a5_hold.d", 32'(bank_d), 32'hA5);

    // op=00 is never granted.
    req0 = 1'b1; op0 = 2'b00;
    step(); step(); chk_ctl("nop_req", 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    req0 = 1'b0;

    // Requester 1 preset then clear on addr 1; grant-cycle consumes the request.
    req1 = 1'b1; op1 = 2'b10; addr1 = 2'd1;
    step(); chk_ctl("preset1", 0, 1, 0, 4'b0000, 4'b0010, 4'b0000);
    op1 = 2'b11;
    step(); chk_ctl("gap1", 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    step(); chk_ctl("clear1", 0, 1, 0, 4'b0000, 4'b0000, 4'b0010);
    req1 = 1'b0; op1 = 2'b00;
    step(); chk_ctl("idle1", 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);

    // Both held: strict alternation starting with requester 0.
    req0 = 1'b1; op0 = 2'b01; addr0 = 2'd0; data0 = 8'h11;
    req1 = 1'b1; op1 = 2'b01; addr1 = 2'd3; data1 = 8'h22;
    step(); chk_ctl("alt0", 1, 0, 0, 4'b0001, 4'b0000, 4'b0000);
    chk("alt0.d", 32'(bank_d), 32'h11);
    step(); chk_ctl("alt1", 0, 1, 0, 4'b1000, 4'b0000, 4'b0000);
    chk("alt1.d", 32'(bank_d), 32'h22);
    step(); chk_ctl("alt2", 1, 0, 0, 4'b0001, 4'b0000, 4'b0000);
    step(); chk_ctl("alt3", 0, 1, 0, 4'b1000, 4'b0000, 4'b0000);
    req0 = 1'b0; req1 = 1'b0; op0 = 2'b00; op1 = 2'b00;
    step(); chk_ctl("alt_idle", 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);

    // clr_all beats a simultaneous request; request served after the sweep.
    clr_all = 1'b1;
    req0 = 1'b1; op0 = 2'b01; addr0 = 2'd1; data0 = 8'h5A;
    step(); chk_ctl("clr_sw0", 0, 0, 1, 4'b0000, 4'b0000, 4'b0001);
    clr_all = 1'b0;
    step(); chk_ctl("clr_sw1", 0, 0, 1, 4'b0000, 4'b0000, 4'b0010);
    step(); chk_ctl("clr_sw2", 0, 0, 1, 4'b0000, 4'b0000, 4'b0100);
    step(); chk_ctl("clr_sw3", 0, 0, 1, 4'b0000, 4'b0000, 4'b1000);
    step(); chk_ctl("clr_idle", 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    step(); chk_ctl("clr_gnt", 1, 0, 0, 4'b0010, 4'b0000, 4'b0000);
    chk("clr_gnt.d", 32'(bank_d), 32'h5A);
    req0 = 1'b0; op0 = 2'b00;
    step();

    // Reset asserted mid-sweep at idx 2, then the sweep reruns from idx 0.
    clr_all = 1'b1;
    step(); chk_ctl("rs_sw0", 0, 0, 1, 4'b0000, 4'b0000, 4'b0001);
    clr_all = 1'b0;
    step(); step(); chk_ctl("rs_sw2", 0, 0, 1, 4'b0000, 4'b0000, 4'b0100);
    reset_n = 1'b0;
    step(); chk_ctl("rs_mid", 0, 0, 1, 4'b0000, 4'b0000, 4'b0000);
    reset_n = 1'b1;
    step(); chk_ctl("rs_re0", 0, 0, 1, 4'b0000, 4'b0000, 4'b0001);
    step(); chk_ctl("rs_re1", 0, 0, 1, 4'b0000, 4'b0000, 4'b0010);
    step(); chk_ctl("rs_re2", 0, 0, 1, 4'b0000, 4'b0000, 4'b0100);
    step(); chk_ctl("rs_re3", 0, 0, 1, 4'b0000, 4'b0000, 4'b1000);
    step(); chk_ctl("rs_done", 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);

    // NUM_REGS=3, addr=3: grant pulses but nothing reaches the bank.
    chk("oor.busy_pre", 32'(busy3), 32'(0));
    r3_req0 = 1'b1; r3_op0 = 2'b01; r3_addr0 = 2'd3; r3_data0 = 8'hFF;
    step();
    chk("oor.gnt0", 32'(g3_0), 32'(1));
    chk("oor.gnt1", 32'(g3_1), 32'(0));
    chk("oor.we",   32'(we3),  32'(0));
    chk("oor.set",  32'(set3), 32'(0));
    chk("oor.rst",  32'(rst3), 32'(0));
    r3_op0 = 2'b10;
    step(); step();
    chk("oor_preset.gnt0", 32'(g3_0), 32'(1));
    chk("oor_preset.set",  32'(set3), 32'(0));
    r3_req0 = 1'b0; r3_op0 = 2'b00;
    step();
    chk("oor.gnt0_after", 32'(g3_0), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
